// File: rtl/output_gate_pkg.sv
// -----------------------------------------------------------------------------
// output_gate_pkg
// Shared definitions for the synthesizer output stage:
//   - gate_state_e   : output window state machine encoding
//   - DEF_*          : default delay / width constants
//   - cnt_width()    : width of the start/stop delay counters
// -----------------------------------------------------------------------------
package output_gate_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } gate_state_e;

  localparam int DEF_DATA_W      = 12;
  localparam int DEF_N_SRC       = 3;
  localparam int DEF_START_DELAY = 27;
  localparam int DEF_STOP_DELAY  = 3;
  localparam int DEF_IDLE_VALUE  = 0;

  // Counter width large enough to hold the larger delay without wrapping.
  function automatic int cnt_width(input int start_delay, input int stop_delay);
    int max_delay;
    int w;
    max_delay = (start_delay > stop_delay) ? start_delay : stop_delay;
    w = $clog2(max_delay + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/output_gate_delay_counter.sv
// -----------------------------------------------------------------------------
// delay_counter
// Clearable up-counter that increments while enabled and saturates at LIMIT.
// Ports:
//   clk   in  system clock, rising edge
//   rst_n in  asynchronous active-low reset
//   clr   in  synchronous clear to zero (has priority over en)
//   en    in  count enable
//   done  out high while the count equals LIMIT
// -----------------------------------------------------------------------------
module delay_counter #(
  parameter int W     = 5,
  parameter int LIMIT = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] count;

  // Count register: clear wins, then increment until the limit is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= {W{1'b0}};
    end else if (clr) begin
      count <= {W{1'b0}};
    end else if (en && (count != LIM)) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

  assign done = (count == LIM);

endmodule

// File: rtl/output_gate.sv
// -----------------------------------------------------------------------------
// output_gate
// Output stage between the signal generators and the DAC interface. A start
// strobe selects the highest-priority requesting source, waits START_DELAY
// cycles to line up with the generator pipeline, then registers that source's
// sample every cycle. The source's stop strobe drains the window for
// STOP_DELAY cycles before returning to the idle level.
//
// Build option: define OUTPUT_TRISTATE_EN to drive REG_OUT to all-'z' whenever
// OUT_VALID is low (IDLE_VALUE unused); otherwise REG_OUT holds IDLE_VALUE.
//
// Ports:
//   CLK       in  system clock, rising edge
//   RESET_N   in  asynchronous active-low reset
//   DATA_IN   in  packed samples, source i at [i*DATA_W +: DATA_W]
//   START     in  per-source start strobes (index 0 highest priority)
//   STOP      in  per-source stop strobes
//   READY     out high only while idle
//   OUT_VALID out REG_OUT holds a live sample
//   REG_OUT   out registered output sample
//   SRC_SEL   out index of the active source
//   BUSY_ERR  out one-cycle pulse when a start arrives while not idle
// -----------------------------------------------------------------------------
module output_gate
  import output_gate_pkg::*;
#(
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                N_SRC       = DEF_N_SRC,
  parameter int                START_DELAY = DEF_START_DELAY,
  parameter int                STOP_DELAY  = DEF_STOP_DELAY,
  parameter logic [DATA_W-1:0] IDLE_VALUE  = DATA_W'(DEF_IDLE_VALUE)
) (
  input  logic                                    CLK,
  input  logic                                    RESET_N,
  input  logic [N_SRC*DATA_W-1:0]                 DATA_IN,
  input  logic [N_SRC-1:0]                        START,
  input  logic [N_SRC-1:0]                        STOP,
  output logic                                    READY,
  output logic                                    OUT_VALID,
  output logic [DATA_W-1:0]                       REG_OUT,
  output logic [((N_SRC > 1) ? $clog2(N_SRC) : 1)-1:0] SRC_SEL,
  output logic                                    BUSY_ERR
);

  localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CNT_W = cnt_width(START_DELAY, STOP_DELAY);

  gate_state_e       state;
  gate_state_e       next_state;
  logic [SEL_W-1:0]  src_sel;
  logic [SEL_W-1:0]  start_idx;
  logic              any_start;
  logic              accept;
  logic              stop_hit;
  logic              stop_flag;
  logic              start_done;
  logic              stop_done;
  logic              busy_err_next;
  logic              live_next;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] sample;
  logic              ready_q;
  logic              valid_q;
  logic              busy_err_q;

  assign any_start = |START;
  assign sel_data  = DATA_IN[int'(src_sel)*DATA_W +: DATA_W];

  // Priority encoder: lowest set START bit wins (scan downward so it lands last).
  always_comb begin
    start_idx = {SEL_W{1'b0}};
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (START[i]) begin
        start_idx = SEL_W'(i);
      end else begin
        start_idx = start_idx;
      end
    end
  end

  delay_counter #(
    .W    (CNT_W),
    .LIMIT(START_DELAY)
  ) u_start_cnt (
    .clk  (CLK),
    .rst_n(RESET_N),
    .clr  (accept),
    .en   (state == ARM),
    .done (start_done)
  );

  // Stop count starts at the first captured stop and keeps running (saturating)
  // through ARM, RUN and DRAIN.
  delay_counter #(
    .W    (CNT_W),
    .LIMIT(STOP_DELAY)
  ) u_stop_cnt (
    .clk  (CLK),
    .rst_n(RESET_N),
    .clr  (stop_hit),
    .en   (stop_flag),
    .done (stop_done)
  );

  // Next-state logic plus the per-edge strobes derived from it.
  always_comb begin
    next_state    = state;
    accept        = 1'b0;
    stop_hit      = 1'b0;
    busy_err_next = 1'b0;
    case (state)
      IDLE: begin
        if (any_start) begin
          accept     = 1'b1;
          next_state = ARM;
        end else begin
          next_state = IDLE;
        end
      end
      ARM: begin
        busy_err_next = any_start;
        stop_hit      = STOP[src_sel] && !stop_flag;
        if (start_done) begin
          // A stop that already ran out during ARM means the window is empty.
          if (stop_flag && stop_done) begin
            next_state = IDLE;
          end else begin
            next_state = RUN;
          end
        end else begin
          next_state = ARM;
        end
      end
      RUN: begin
        busy_err_next = any_start;
        stop_hit      = STOP[src_sel] && !stop_flag;
        // stop_flag set on entry means the stop arrived in ARM; its count may
        // already be exhausted after the single RUN sample.
        if (stop_flag && stop_done) begin
          next_state = IDLE;
        end else if (stop_flag || stop_hit) begin
          next_state = DRAIN;
        end else begin
          next_state = RUN;
        end
      end
      DRAIN: begin
        busy_err_next = any_start;
        if (stop_done) begin
          next_state = IDLE;
        end else begin
          next_state = DRAIN;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign live_next = (next_state == RUN) || (next_state == DRAIN);

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Stop flag: cleared on a new window, set by the first accepted stop.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stop_flag <= 1'b0;
    end else if (accept) begin
      stop_flag <= 1'b0;
    end else if (stop_hit) begin
      stop_flag <= 1'b1;
    end else begin
      stop_flag <= stop_flag;
    end
  end

  // Source select latch, updated only when a window is accepted.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      src_sel <= {SEL_W{1'b0}};
    end else if (accept) begin
      src_sel <= start_idx;
    end else begin
      src_sel <= src_sel;
    end
  end

  // Output registers, all loaded from next-state so they line up with the state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      busy_err_q <= 1'b0;
`ifdef OUTPUT_TRISTATE_EN
      sample     <= {DATA_W{1'b0}};
`else
      sample     <= IDLE_VALUE;
`endif
    end else begin
      ready_q    <= (next_state == IDLE);
      valid_q    <= live_next;
      busy_err_q <= busy_err_next;
      if (live_next) begin
        sample <= sel_data;
      end else begin
`ifdef OUTPUT_TRISTATE_EN
        sample <= {DATA_W{1'b0}};
`else
        sample <= IDLE_VALUE;
`endif
      end
    end
  end

  assign READY     = ready_q;
  assign OUT_VALID = valid_q;
  assign BUSY_ERR  = busy_err_q;
  assign SRC_SEL   = src_sel;

`ifdef OUTPUT_TRISTATE_EN
  assign REG_OUT = valid_q ? sample : {DATA_W{1'bz}};
`else
  assign REG_OUT = sample;
`endif

endmodule

// File: tb/tb_output_gate.sv
// -----------------------------------------------------------------------------
// tb_output_gate
// Self-checking bench for output_gate. A reference model works on edge
// numbers (start edge k, stop capture edge m) and pushes the expected output
// after every clock edge into a queue; a monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_output_gate;

  localparam int          DATA_W = 12;
  localparam int          N_SRC  = 3;
  localparam int          SD     = 27;
  localparam int          PD     = 3;
  localparam logic [11:0] IDLE_V = 12'h800;
`ifdef OUTPUT_TRISTATE_EN
  localparam logic [11:0] IDLE_EXP = 12'hzzz;
`else
  localparam logic [11:0] IDLE_EXP = IDLE_V;
`endif

  logic                    CLK = 1'b0;
  logic                    RESET_N = 1'b0;
  logic [N_SRC*DATA_W-1:0] DATA_IN = '0;
  logic [N_SRC-1:0]        START = '0;
  logic [N_SRC-1:0]        STOP = '0;
  logic                    READY;
  logic                    OUT_VALID;
  logic [DATA_W-1:0]       REG_OUT;
  logic [1:0]              SRC_SEL;
  logic                    BUSY_ERR;

  always #5 CLK = ~CLK;

  output_gate #(
    .DATA_W     (DATA_W),
    .N_SRC      (N_SRC),
    .START_DELAY(SD),
    .STOP_DELAY (PD),
    .IDLE_VALUE (IDLE_V)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .DATA_IN  (DATA_IN),
    .START    (START),
    .STOP     (STOP),
    .READY    (READY),
    .OUT_VALID(OUT_VALID),
    .REG_OUT  (REG_OUT),
    .SRC_SEL  (SRC_SEL),
    .BUSY_ERR (BUSY_ERR)
  );

  typedef struct packed {
    logic        ready;
    logic        valid;
    logic [11:0] out;
    logic [1:0]  sel;
    logic        berr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   dmode  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int lowest(input logic [2:0] v);
    for (int i = 0; i < 3; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  // Reference model: one window = start edge k, optional stop capture edge m.
  // Live samples at edges k+SD+1 .. m+PD; back to idle at max(k+SD+1, m+PD+1).
  initial begin : model
    int  e;
    bit  busy;
    int  k;
    int  m;
    int  src;
    int  first;
    int  fin;
    exp_t x;
    e = 0; busy = 0; k = 0; m = -1; src = 0;
    forever begin
      @(posedge CLK);
      e++;
      if (!RESET_N) begin
        busy = 0;
        src  = 0;
      end else begin
        x.berr = busy && (START != 3'b000);
        if (!busy) begin
          if (START != 3'b000) begin
            busy = 1; k = e; m = -1; src = lowest(START);
          end
          x.ready = !busy;
          x.valid = 1'b0;
          x.out   = IDLE_EXP;
        end else begin
          first = k + SD + 1;
          if (m < 0 && STOP[src]) m = e;
          fin = (m >= 0) ? ((first > m + PD + 1) ? first : m + PD + 1) : -1;
          if (m >= 0 && e == fin) begin
            busy    = 0;
            x.ready = 1'b1;
            x.valid = 1'b0;
            x.out   = IDLE_EXP;
          end else if (e >= first) begin
            x.ready = 1'b0;
            x.valid = 1'b1;
            x.out   = DATA_IN[src*DATA_W +: DATA_W];
          end else begin
            x.ready = 1'b0;
            x.valid = 1'b0;
            x.out   = IDLE_EXP;
          end
        end
        x.sel = 2'(src);
        exp_q.push_back(x);
      end
    end
  end

  // Monitor: compare DUT outputs just after each edge against the model.
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge CLK);
      #1;
      while (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("ready",    16'(READY),     16'(x.ready));
        check("valid",    16'(OUT_VALID), 16'(x.valid));
        check("reg_out",  16'(REG_OUT),   16'(x.out));
        check("src_sel",  16'(SRC_SEL),   16'(x.sel));
        check("busy_err", 16'(BUSY_ERR),  16'(x.berr));
      end
    end
  end

  // Data driver: ramp on source 0, fixed pattern, or random.
  initial begin : data_drv
    logic [11:0] ramp;
    ramp = 12'h000;
    forever begin
      @(negedge CLK);
      case (dmode)
        0: begin
          DATA_IN = {12'($urandom), 12'($urandom), ramp};
          ramp    = ramp + 12'h001;
        end
        2: DATA_IN = {12'h3C3, 12'hA5A, 12'h111};
        default: DATA_IN = 36'({$urandom, $urandom});
      endcase
    end
  end

  task automatic drive1(input logic [2:0] s, input logic [2:0] p);
    @(negedge CLK);
    START = s;
    STOP  = p;
  endtask

  task automatic idle_n(input int n);
    repeat (n) drive1(3'b000, 3'b000);
  endtask

  task automatic wait_ready(input int max_cyc);
    int n;
    n = 0;
    drive1(3'b000, 3'b000);
    while (!READY && n < max_cyc) begin
      drive1(3'b000, 3'b000);
      n++;
    end
    check("ready_timeout", 16'(READY), 16'd1);
  endtask

  initial begin : stim
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_ready", 16'(READY),     16'd1);
    check("rst_valid", 16'(OUT_VALID), 16'd0);
    check("rst_out",   16'(REG_OUT),   16'(IDLE_EXP));
    check("rst_sel",   16'(SRC_SEL),   16'd0);
    check("rst_berr",  16'(BUSY_ERR),  16'd0);
    RESET_N = 1'b1;
    idle_n(5);

    // Ramp on source 0, stop well into RUN.
    dmode = 0;
    drive1(3'b001, 3'b000);
    idle_n(49);
    drive1(3'b000, 3'b001);
    wait_ready(20);
    idle_n(2);

    // Two simultaneous starts: source 1 wins; STOP[2] ignored, STOP[1] ends.
    dmode = 2;
    drive1(3'b110, 3'b000);
    idle_n(35);
    drive1(3'b000, 3'b100);
    idle_n(5);
    drive1(3'b000, 3'b010);
    wait_ready(20);

    // Stop two cycles after start: empty window.
    dmode = 1;
    drive1(3'b001, 3'b000);
    idle_n(1);
    drive1(3'b000, 3'b001);
    wait_ready(40);

    // Stop late in ARM: short window with remaining stop count.
    drive1(3'b100, 3'b000);
    idle_n(25);
    drive1(3'b000, 3'b100);
    wait_ready(40);

    // Start during RUN raises BUSY_ERR only.
    drive1(3'b001, 3'b000);
    idle_n(32);
    drive1(3'b100, 3'b000);
    idle_n(5);
    drive1(3'b000, 3'b001);
    wait_ready(20);

    // Reset in the middle of RUN.
    drive1(3'b010, 3'b000);
    idle_n(33);
    #2 RESET_N = 1'b0;
    #1;
    check("midrst_ready", 16'(READY),     16'd1);
    check("midrst_valid", 16'(OUT_VALID), 16'd0);
    check("midrst_out",   16'(REG_OUT),   16'(IDLE_EXP));
    check("midrst_sel",   16'(SRC_SEL),   16'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    idle_n(2);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drive1(($urandom_range(0, 19) == 0) ? 3'($urandom) : 3'b000,
             ($urandom_range(0, 11) == 0) ? 3'($urandom) : 3'b000);
    end
    drive1(3'b000, 3'b111);
    wait_ready(60);
    idle_n(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_gate.md
# output_gate

Parametrised output stage of the digital synthesizer. It sits between the signal generators (LFM/PSK phase-to-amplitude ROM path, noise buffer, and any further sources) and the DAC interface. On a per-source start strobe it aligns the output window to the generator pipeline latency with a start delay, then registers the selected source's sample every cycle. On that source's stop strobe it drains for a stop delay and returns the output to its idle level.

## Interface
- DATA_W, 12, sample width
- N_SRC, 3, number of sources; index 0 has the highest priority
- START_DELAY, 27, cycles from start capture to first registered sample; must be ≥1
- STOP_DELAY, 3, cycles from stop capture to end of output; must be ≥1
- IDLE_VALUE, 0, REG_OUT level when idle (non-tristate build)
- CLK  in  1  system clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- DATA_IN  in  N_SRC*DATA_W  packed source samples; source i occupies [i*DATA_W +: DATA_W]
- START  in  N_SRC  per-source start-of-calculation strobes
- STOP  in  N_SRC  per-source stop-of-calculation strobes
- READY  out  1  high only in IDLE
- OUT_VALID  out  1  REG_OUT holds a live sample
- REG_OUT  out  DATA_W  registered output sample
- SRC_SEL  out  $clog2(N_SRC) (min 1)  index of the active source
- BUSY_ERR  out  1  one-cycle pulse: a start arrived while not IDLE

## Operation
- States: IDLE, ARM, RUN, DRAIN.
- IDLE: at a clock edge where any START bit is high, the lowest set index is latched into SRC_SEL, the start counter clears, and the block moves to ARM with READY low.
- ARM: the start counter increments every cycle. When it reaches START_DELAY, the next edge moves to RUN.
- RUN: every edge, REG_OUT takes DATA_IN[SRC_SEL] and OUT_VALID is 1.
- Stop capture: STOP[SRC_SEL] is sampled in ARM and RUN. The first assertion sets a stop flag and clears the stop counter. The counter then increments each cycle up to STOP_DELAY and saturates there. STOP bits of other sources and repeated assertions are ignored.
- A stop captured in RUN moves the block to DRAIN. Sampling continues in DRAIN.
- DRAIN: when the stop counter equals STOP_DELAY, the next edge returns to IDLE. On that edge REG_OUT goes to the idle level, OUT_VALID goes to 0 and READY goes to 1.
- Stop captured during ARM: the stop counter runs concurrently with the start counter.
  - If the stop counter has saturated when ARM completes, the block goes ARM→IDLE with no RUN cycles (OUT_VALID never rises).
  - Otherwise the block enters RUN and then DRAIN with the remaining stop count.
- START while not IDLE: ignored, and BUSY_ERR pulses for one cycle on each such edge.
- START and STOP in the same cycle while IDLE: the start is taken and the stop is ignored.
- RESET_N low at any time: immediate return to IDLE with all outputs at their reset values, regardless of the current state.
- Counters are $clog2(max(START_DELAY,STOP_DELAY)+1) bits wide and never wrap.

## Timing
- Reset values: READY=1, OUT_VALID=0, REG_OUT=idle level, SRC_SEL=0, BUSY_ERR=0.
- START sampled high at edge k gives first sample at edge k+START_DELAY+1. That value is DATA_IN as presented before that edge.
- STOP captured at edge m in RUN:
  - last live sample at edge m+STOP_DELAY;
  - idle level and READY=1 at edge m+STOP_DELAY+1.
- The earliest accepted restart is the edge after READY rises.
- Output latency in RUN is one register stage.

## Configuration
- OUTPUT_TRISTATE_EN defined: REG_OUT drives all-'z' whenever OUT_VALID=0, including reset. IDLE_VALUE is unused.
- OUTPUT_TRISTATE_EN undefined: REG_OUT drives IDLE_VALUE whenever OUT_VALID=0. All other behaviour is identical.

## Structure
- Package output_gate_pkg holds:
  - the state enum (IDLE/ARM/RUN/DRAIN);
  - the default delay constants;
  - a function computing the counter width.
- Sub-module delay_counter: clear / enable / saturate-at-limit counter with a "done" output. It is instantiated twice, for the start and stop counts.

## Test plan
- Reset mid-RUN (DATA_W=12, N_SRC=3, START_DELAY=27, STOP_DELAY=3): RESET_N low during RUN → immediately OUT_VALID=0, REG_OUT idle, READY=1.
- START[0] pulse at edge 10, DATA_IN[0] ramping 0x000,0x001,… → OUT_VALID rises at edge 38 with the ramp value from before edge 38. STOP[0] at edge 60 → last sample at edge 63, READY=1 at edge 64.
- START=3'b110 at the same edge → SRC_SEL=1, DATA_IN[1]=0xA5A appears on REG_OUT. STOP[2] is ignored; STOP[1] ends the window.
- STOP[0] captured 2 cycles after START[0] → ARM→IDLE, OUT_VALID never asserts, READY returns at edge k+28.
- START[2] pulse during RUN → BUSY_ERR pulses once, and SRC_SEL and the output stream are unchanged.
- Both builds: with OUTPUT_TRISTATE_EN, REG_OUT===12'hzzz in IDLE; without it and IDLE_VALUE=12'h800, REG_OUT==12'h800 in IDLE.
